// File: rtl/cpu_pkg.sv
// Types and constants shared between the front-end pipeline stages.
package cpu_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  // AArch64 NOP, presented to decode whenever the queue has nothing valid
  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

endpackage

// File: rtl/sync_fifo_ptrs.sv
// Read/write pointer and occupancy tracking for a small power-of-two FIFO.
// Carries no data, so it can be reused by any buffer that owns its own storage.
module sync_fifo_ptrs #(
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [PW-1:0] wr_ptr_o,
  output logic [PW-1:0] rd_ptr_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      // Collapse onto the write pointer; storage contents become unreachable
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode decoupling queue: buffers {pc, instruction} pairs so fetch can run
// ahead while decode stalls, back-pressures the PC, and squashes on a taken branch.
module fetch_decode_queue
  import cpu_pkg::*;
#(
  parameter int              DEPTH     = 2,
  parameter int              AW        = 64,
  parameter int              IW        = 32,
  parameter logic [IW-1:0]   NOP_WORD  = IW'(cpu_pkg::NOP_INSTR),
  parameter int              PW        = $clog2(DEPTH),
  parameter int              CW        = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_valid,
  input  logic [AW-1:0] if_pc,
  input  logic [IW-1:0] if_instruction,
  output logic          if_ready,
  input  logic          flush,
  output logic          id_valid,
  output logic [AW-1:0] id_pc,
  output logic [IW-1:0] id_instruction,
  input  logic          id_ready,
  output logic [CW-1:0] occupancy
);

  fetch_pkt_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic                   full, empty, push, pop;

  // Ready comes from registered count and decode's consume only, never from if_*
  assign id_valid = !empty;
  assign if_ready = !full | (id_valid & id_ready);
  assign push     = if_valid & if_ready & !flush;
  assign pop      = id_valid & id_ready & !flush;

  sync_fifo_ptrs #(.DEPTH(DEPTH)) u_ptrs (
    .clk      (clk),
    .reset    (reset),
    .push_i   (push),
    .pop_i    (pop),
    .flush_i  (flush),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .count_o  (occupancy),
    .full_o   (full),
    .empty_o  (empty)
  );

  // Storage is not reset; the pointer block alone decides which entries are live
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr].pc    <= 64'(if_pc);
      mem_q[wr_ptr].instr <= 32'(if_instruction);
    end
  end

  assign id_pc          = id_valid ? AW'(mem_q[rd_ptr].pc)    : '0;
  assign id_instruction = id_valid ? IW'(mem_q[rd_ptr].instr) : NOP_WORD;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scenario bench for fetch_decode_queue: expected words are queued when accepted by
// fetch and compared when decode consumes them; occupancy is checked against that queue.
module tb_fetch_decode_queue;
  import cpu_pkg::*;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_valid = 1'b0;
  logic [63:0] if_pc = '0;
  logic [31:0] if_instruction = '0;
  logic        if_ready;
  logic        flush = 1'b0;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instruction;
  logic        id_ready = 1'b0;
  logic [1:0]  occupancy;

  int npass = 0;
  int ntot  = 0;
  fetch_pkt_t sb[$];

  fetch_decode_queue dut (
    .clk            (clk),
    .reset          (reset),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .if_ready       (if_ready),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instruction (id_instruction),
    .id_ready       (id_ready),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  // One clock: at the falling edge the inputs are stable, so account for what the
  // coming rising edge will pop and push; inputs then change 2 time units after it.
  task automatic cyc();
    fetch_pkt_t e;
    @(negedge clk);
    if (!reset || flush) begin
      sb.delete();
    end else begin
      if (id_valid && id_ready) begin
        ntot++;
        if (sb.size() == 0) $display("FAIL sb_pop: unexpected pop pc=%h, want no valid entry", id_pc);
        else begin
          e = sb.pop_front();
          if (id_pc !== e.pc || id_instruction !== e.instr)
            $display("FAIL sb_pop: got pc=%h ins=%h want pc=%h ins=%h", id_pc, id_instruction, e.pc, e.instr);
          else npass++;
        end
      end
      if (if_valid && if_ready) sb.push_back('{pc: if_pc, instr: if_instruction});
    end
    @(posedge clk);
    #2;
  endtask

  task automatic present(input logic [63:0] pc);
    if_valid       = 1'b1;
    if_pc          = pc;
    if_instruction = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(); cyc();
    ntot++; if (id_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", id_valid); else npass++;
    ntot++; if (id_instruction !== NOP) $display("FAIL rst_instr: got %h want %h", id_instruction, NOP); else npass++;
    ntot++; if (id_pc !== 64'd0) $display("FAIL rst_pc: got %h want 0", id_pc); else npass++;
    ntot++; if (if_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", if_ready); else npass++;
    ntot++; if (occupancy !== 2'd0) $display("FAIL rst_occ: got %0d want 0", occupancy); else npass++;
    reset = 1'b1;
    cyc(); cyc();
    ntot++; if (id_valid !== 1'b0 || id_instruction !== NOP || if_ready !== 1'b1 || occupancy !== 2'd0)
      $display("FAIL idle_after_rst: got v=%b ins=%h rdy=%b occ=%0d want 0/%h/1/0", id_valid, id_instruction, if_ready, occupancy, NOP);
    else npass++;
  endtask

  task automatic test_streaming();
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      present(64'(i * 4));
      #1;
      ntot++; if (if_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %b want 1", i, if_ready); else npass++;
      cyc();
      ntot++; if (id_pc !== 64'(i * 4) || occupancy !== 2'd1)
        $display("FAIL stream_head[%0d]: got pc=%h occ=%0d want pc=%h occ=1", i, id_pc, occupancy, 64'(i * 4));
      else npass++;
    end
    if_valid = 1'b0;
    cyc();
    ntot++; if (occupancy !== 2'd0) $display("FAIL stream_drain: got %0d want 0", occupancy); else npass++;
  endtask

  task automatic test_backpressure();
    id_ready = 1'b0;
    present(64'd0); cyc();
    present(64'd4); cyc();
    present(64'd8); #1;
    ntot++; if (if_ready !== 1'b0 || occupancy !== 2'd2)
      $display("FAIL bp_full: got rdy=%b occ=%0d want 0/2", if_ready, occupancy); else npass++;
    cyc();
    ntot++; if (occupancy !== 2'd2 || id_pc !== 64'd0 || sb.size() != 2)
      $display("FAIL bp_hold: got occ=%0d pc=%h sb=%0d want 2/0/2", occupancy, id_pc, sb.size()); else npass++;
    id_ready = 1'b1; #1;
    ntot++; if (if_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", if_ready); else npass++;
    cyc();
    if_valid = 1'b0;
    ntot++; if (id_pc !== 64'd4 || occupancy !== 2'd2)
      $display("FAIL bp_pop0: got pc=%h occ=%0d want 4/2", id_pc, occupancy); else npass++;
    cyc();
    ntot++; if (id_pc !== 64'd8 || occupancy !== 2'd1)
      $display("FAIL bp_pop4: got pc=%h occ=%0d want 8/1", id_pc, occupancy); else npass++;
    cyc();
    ntot++; if (occupancy !== 2'd0 || id_valid !== 1'b0)
      $display("FAIL bp_empty: got occ=%0d v=%b want 0/0", occupancy, id_valid); else npass++;
  endtask

  task automatic test_full_push_pop();
    id_ready = 1'b0;
    present(64'h100); cyc();
    present(64'h104); cyc();
    id_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      present(64'h200 + 64'(i * 4));
      #1;
      ntot++; if (if_ready !== 1'b1) $display("FAIL full_pp_ready[%0d]: got %b want 1", i, if_ready); else npass++;
      cyc();
      ntot++; if (occupancy !== 2'd2 || occupancy !== 2'(sb.size()))
        $display("FAIL full_pp_occ[%0d]: got %0d want 2 (sb=%0d)", i, occupancy, sb.size()); else npass++;
    end
    if_valid = 1'b0;
    cyc(); cyc();
    ntot++; if (occupancy !== 2'd0 || sb.size() != 0)
      $display("FAIL full_pp_drain: got occ=%0d sb=%0d want 0/0", occupancy, sb.size()); else npass++;
  endtask

  task automatic test_flush();
    id_ready = 1'b0;
    present(64'h10); cyc();
    present(64'h14); cyc();
    present(64'h99);
    flush = 1'b1;
    cyc();
    flush    = 1'b0;
    if_valid = 1'b0;
    #1;
    ntot++; if (occupancy !== 2'd0 || id_valid !== 1'b0 || id_instruction !== NOP || id_pc !== 64'd0)
      $display("FAIL flush_clear: got occ=%0d v=%b ins=%h pc=%h want 0/0/%h/0", occupancy, id_valid, id_instruction, id_pc, NOP);
    else npass++;
    present(64'h40); cyc();
    if_valid = 1'b0;
    ntot++; if (id_valid !== 1'b1 || id_pc !== 64'h40 || occupancy !== 2'd1)
      $display("FAIL flush_next: got v=%b pc=%h occ=%0d want 1/40/1", id_valid, id_pc, occupancy); else npass++;
    id_ready = 1'b1;
    cyc();
    ntot++; if (occupancy !== 2'd0) $display("FAIL flush_drain: got %0d want 0", occupancy); else npass++;
  endtask

  task automatic test_async_reset();
    id_ready = 1'b0;
    present(64'h60); cyc();
    present(64'h64); cyc();
    if_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    ntot++; if (id_valid !== 1'b0 || id_instruction !== NOP || id_pc !== 64'd0 || if_ready !== 1'b1 || occupancy !== 2'd0)
      $display("FAIL async_rst: got v=%b ins=%h pc=%h rdy=%b occ=%0d want 0/%h/0/1/0", id_valid, id_instruction, id_pc, if_ready, occupancy, NOP);
    else npass++;
    cyc();
    reset = 1'b1;
    cyc();
    ntot++; if (id_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL async_rst_stale: got v=%b occ=%0d want 0/0", id_valid, occupancy); else npass++;
    present(64'h80); cyc();
    if_valid = 1'b0;
    ntot++; if (id_pc !== 64'h80 || occupancy !== 2'd1)
      $display("FAIL async_rst_push: got pc=%h occ=%0d want 80/1", id_pc, occupancy); else npass++;
    id_ready = 1'b1;
    cyc();
    ntot++; if (occupancy !== 2'd0 || sb.size() != 0)
      $display("FAIL async_rst_drain: got occ=%0d sb=%0d want 0/0", occupancy, sb.size()); else npass++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_full_push_pop();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
